fp_norm_round: RTL

- Pipelined normalize-and-round stage directly downstream of the 24x24 radix-8 MBE mantissa multiplier in the single-precision FP multiplier datapath.
- Consumes the 48-bit mantissa product plus the sign, the pre-computed exponent and the special-case class from the unpacking stage.
- Produces a packed IEEE-754 binary32 result and status flags.
- Two register stages with a valid/ready handshake. Full throughput of 1 result per cycle when not stalled.

---
 rtl/fp_pkg.sv | 45 ++++
 rtl/fp_rounder.sv | 47 ++++
 rtl/fp_norm_round.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the single-precision normalize/round stage.
//   fp_class_e : special-case class resolved by the unpacking stage
//   s1_t       : contents of the normalize (S1) pipeline register
//   fp_inf / fp_zero : packing helpers for signed infinity and signed zero
// The S1 exponent is carried at S1_EXP_W bits so that the +1 from
// normalization and the +1 from a rounding carry can never wrap.
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int MANT_W   = 23;
   localparam int PROD_W   = 48;
   localparam int EXP_MAX  = 255;
   localparam int S1_EXP_W = 12;

   localparam logic [31:0]                QNAN     = 32'h7FC0_0000;
   localparam logic signed [S1_EXP_W-1:0] EXP_ONE  = {{(S1_EXP_W-1){1'b0}}, 1'b1};
   localparam logic signed [S1_EXP_W-1:0] EXP_ZERO = {S1_EXP_W{1'b0}};

   typedef enum logic [1:0] {
      FP_NORMAL = 2'b00,
      FP_ZERO   = 2'b01,
      FP_INF    = 2'b10,
      FP_NAN    = 2'b11
   } fp_class_e;

   typedef struct packed {
      logic                         sign;
      logic signed [S1_EXP_W-1:0]   exp;
      logic [MANT_W-1:0]            mant;
      logic                         guard;
      logic                         sticky;
      fp_class_e                    cls;
   } s1_t;

   function automatic logic [31:0] fp_inf(input logic sign);
      return {sign, 8'hFF, 23'h00_0000};
   endfunction

   function automatic logic [31:0] fp_zero(input logic sign);
      return {sign, 31'h0000_0000};
   endfunction

endpackage

// File: rtl/fp_rounder.sv
// -----------------------------------------------------------------------------
// fp_rounder
// Combinational rounding of a normalized 23-bit fraction.
//   mant, guard, sticky, exp : normalized fraction, round bits, exponent
//   mant_rnd, exp_rnd        : rounded fraction and carry-adjusted exponent
//   inexact                  : any discarded bit was non-zero
// Macro FP_NORM_ROUND_RNE_EN: defined -> round to nearest even;
// undefined -> truncation (no increment, no carry path).
// -----------------------------------------------------------------------------
module fp_rounder
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0]          mant,
   input  logic                       guard,
   input  logic                       sticky,
   input  logic signed [S1_EXP_W-1:0] exp,
   output logic [MANT_W-1:0]          mant_rnd,
   output logic signed [S1_EXP_W-1:0] exp_rnd,
   output logic                       inexact
);

`ifdef FP_NORM_ROUND_RNE_EN
   logic            inc_s;
   logic [MANT_W:0] sum_s;

   // Ties go to the even fraction: only bump when above half or LSB is odd.
   assign inc_s = guard & (sticky | mant[0]);
   assign sum_s = {1'b0, mant} + {{MANT_W{1'b0}}, inc_s};

   // Fraction overflow (1.111..1 + ulp) becomes 1.0 at the next exponent.
   always_comb begin
      if (sum_s[MANT_W]) begin
         mant_rnd = {MANT_W{1'b0}};
         exp_rnd  = exp + EXP_ONE;
      end else begin
         mant_rnd = sum_s[MANT_W-1:0];
         exp_rnd  = exp;
      end
   end
`else
   assign mant_rnd = mant;
   assign exp_rnd  = exp;
`endif

   assign inexact = guard | sticky;

endmodule

// File: rtl/fp_norm_round.sv
// -----------------------------------------------------------------------------
// fp_norm_round
// Two-stage normalize (S1) and round/pack (S2) pipeline behind the mantissa
// multiplier of the binary32 multiplier. One result per cycle when unstalled.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   in_sign, in_exp       : product sign, two's-complement biased exponent
//   in_prod               : 48-bit mantissa product (hidden bits included)
//   in_class              : 00 normal, 01 zero, 10 inf, 11 nan
//   out_valid / out_ready : downstream handshake
//   out_result            : packed binary32
//   out_flags             : {overflow, underflow, inexact}
// Macro FP_NORM_ROUND_RNE_EN selects round-to-nearest-even (else truncation).
// in_ready is a pure function of the stage valids and out_ready; there is no
// skid buffer, so a stalled output back-pressures straight to the input.
// -----------------------------------------------------------------------------
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W = 10,
   parameter int BIAS  = 127
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [PROD_W-1:0] in_prod,
   input  logic [1:0]       in_class,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [2:0]       out_flags
);

   // Largest biased exponent that still encodes a finite value is 2*BIAS;
   // clamp to the binary32 field limit.
   localparam int OVF_LIM = ((2 * BIAS + 1) < EXP_MAX) ? (2 * BIAS + 1) : EXP_MAX;
   localparam logic signed [S1_EXP_W-1:0] OVF_EXP = S1_EXP_W'(OVF_LIM);

   logic                       v1_r;
   logic                       v2_r;
   logic                       r1_s;
   s1_t                        s1_r;
   s1_t                        s1_nxt_s;
   logic signed [S1_EXP_W-1:0] exp_ext_s;
   logic [MANT_W-1:0]          mant_rnd_s;
   logic signed [S1_EXP_W-1:0] exp_rnd_s;
   logic                       inexact_s;
   logic [31:0]                result_r;
   logic [31:0]                result_nxt_s;
   logic [2:0]                 flags_r;
   logic [2:0]                 flags_nxt_s;

   assign r1_s     = ~v2_r | out_ready;
   assign in_ready = ~v1_r | r1_s;

   assign exp_ext_s = {{(S1_EXP_W-EXP_W){in_exp[EXP_W-1]}}, in_exp};

   // Normalize: shift so the leading one sits just above the fraction field.
   always_comb begin
      s1_nxt_s.sign = in_sign;
      s1_nxt_s.cls  = fp_class_e'(in_class);
      if (in_prod[PROD_W-1]) begin
         s1_nxt_s.mant   = in_prod[46:24];
         s1_nxt_s.guard  = in_prod[23];
         s1_nxt_s.sticky = |in_prod[22:0];
         s1_nxt_s.exp    = exp_ext_s + EXP_ONE;
      end else begin
         s1_nxt_s.mant   = in_prod[45:23];
         s1_nxt_s.guard  = in_prod[22];
         s1_nxt_s.sticky = |in_prod[21:0];
         s1_nxt_s.exp    = exp_ext_s;
      end
   end

   // S1 register: loads whenever the stage can accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r <= 1'b0;
         s1_r <= '0;
      end else if (in_ready) begin
         v1_r <= in_valid;
         if (in_valid) begin
            s1_r <= s1_nxt_s;
         end
      end
   end

   fp_rounder u_rounder (
      .mant     (s1_r.mant),
      .guard    (s1_r.guard),
      .sticky   (s1_r.sticky),
      .exp      (s1_r.exp),
      .mant_rnd (mant_rnd_s),
      .exp_rnd  (exp_rnd_s),
      .inexact  (inexact_s)
   );

   // Range check after rounding, then special classes override everything.
   always_comb begin
      result_nxt_s = 32'h0000_0000;
      flags_nxt_s  = 3'b000;
      case (s1_r.cls)
         FP_ZERO: result_nxt_s = fp_zero(s1_r.sign);
         FP_INF:  result_nxt_s = fp_inf(s1_r.sign);
         FP_NAN:  result_nxt_s = QNAN;
         FP_NORMAL: begin
            if (exp_rnd_s >= OVF_EXP) begin
               result_nxt_s = fp_inf(s1_r.sign);
               flags_nxt_s  = 3'b101;
            end else if (exp_rnd_s <= EXP_ZERO) begin
               result_nxt_s = fp_zero(s1_r.sign);
               flags_nxt_s  = {1'b0, 1'b1, inexact_s};
            end else begin
               result_nxt_s = {s1_r.sign, exp_rnd_s[7:0], mant_rnd_s};
               flags_nxt_s  = {2'b00, inexact_s};
            end
         end
         default: result_nxt_s = QNAN;
      endcase
   end

   // S2 (output) register: holds while stalled, so outputs stay stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r     <= 1'b0;
         result_r <= 32'h0000_0000;
         flags_r  <= 3'b000;
      end else if (r1_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            result_r <= result_nxt_s;
            flags_r  <= flags_nxt_s;
         end
      end
   end

   assign out_valid  = v2_r;
   assign out_result = result_r;
   assign out_flags  = flags_r;

endmodule
